mux_scan_sequencer: RTL and testbench

- Upstream controller for the 16:1 channel mux. It drives the mux's 4-bit select and samples the single-bit mux output.
- On a start request it sweeps a masked set of the 16 channels in ascending order and waits a programmable settle time on each channel.
- It assembles the sampled bits into a 16-bit snapshot word and hands that word downstream over a valid/ready handshake.

---
 rtl/mux_scan_sequencer.sv | 137 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Sweeps masked channels of a 16:1 mux in ascending order and packs the sampled bits into a snapshot word.
// Valid rises 1+N*(SETTLE+1) edges after start; the snapshot is held in DONE until result_ready, and start is ignored there.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mask,
    output logic [3:0]  sel,
    input  logic        mux_y,
    output logic        busy,
    output logic [15:0] result,
    output logic        result_valid,
    input  logic        result_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mask_q, mask_d;
    logic [15:0] result_q, result_d;

    logic [4:0]  first_hit;
    logic [4:0]  next_hit;
    logic [4:0]  next_from;

    // Returns {found, index} of the lowest set bit of m at or above from.
    function automatic logic [4:0] lowest_from(input logic [15:0] m, input logic [4:0] from);
        logic [4:0] hit;
        hit = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (5'(i) >= from)) begin
                hit = {1'b1, 4'(i)};
            end
        end
        return hit;
    endfunction

    assign next_from = {1'b0, sel_q} + 5'd1;
    assign first_hit = lowest_from(mask, 5'd0);
    assign next_hit  = lowest_from(mask_q, next_from);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 4'd0;
            cnt_q    <= 4'd0;
            mask_q   <= 16'd0;
            result_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (mask != 16'd0) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if ((cnt_q == 4'd0) && !next_hit[4]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    result_d = 16'd0;
                    if (mask != 16'd0) begin
                        mask_d = mask;
                        sel_d  = first_hit[3:0];
                        cnt_d  = SETTLE_CNT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // sel has been stable SETTLE+1 cycles here, so this is the only sampling point.
                    result_d[sel_q] = mux_y;
                    if (next_hit[4]) begin
                        sel_d = next_hit[3:0];
                        cnt_d = SETTLE_CNT;
                    end
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    sel_d = 4'd0;
                end
            end
            default: begin
                sel_d = 4'd0;
                cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        busy         = (state_q == ST_WAIT);
        result_valid = (state_q == ST_DONE);
        sel          = sel_q;
        result       = result_q;
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE=1 and SETTLE=0) with a queue-based scoreboard on sel, latency and result.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1, start0;
    logic [15:0] mask1, mask0;
    logic [15:0] pat1, pat0;
    logic [3:0]  sel1, sel0;
    logic        y1, y0;
    logic        busy1, busy0;
    logic [15:0] res1, res0;
    logic        v1, v0;
    logic        rdy1, rdy0;

    assign y1 = pat1[sel1];
    assign y0 = pat0[sel0];

    mux_scan_sequencer #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mask(mask1), .sel(sel1), .mux_y(y1),
        .busy(busy1), .result(res1), .result_valid(v1), .result_ready(rdy1)
    );

    mux_scan_sequencer #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .mask(mask0), .sel(sel0), .mux_y(y0),
        .busy(busy0), .result(res0), .result_valid(v0), .result_ready(rdy0)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          start_edge;
    } exp_t;

    exp_t       eq1[$], eq0[$];
    logic [3:0] sq1[$], sq0[$];
    exp_t       e1, e0;
    logic       pv1 = 1'b0, pv0 = 1'b0;

    // Monitor: sel is checked every busy cycle, latency and result when valid rises.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy1) begin
                if (sq1.size() == 0) chk("sel1_unexpected_busy", 1, 0);
                else chk("sel1_seq", sel1, sq1.pop_front());
            end
            if (v1 && !pv1) begin
                if (eq1.size() == 0) chk("v1_unexpected", 1, 0);
                else begin
                    e1 = eq1.pop_front();
                    chk("lat1", cyc - e1.start_edge + 1, e1.lat);
                    chk("res1", res1, e1.res);
                end
            end
            if (busy0) begin
                if (sq0.size() == 0) chk("sel0_unexpected_busy", 1, 0);
                else chk("sel0_seq", sel0, sq0.pop_front());
            end
            if (v0 && !pv0) begin
                if (eq0.size() == 0) chk("v0_unexpected", 1, 0);
                else begin
                    e0 = eq0.pop_front();
                    chk("lat0", cyc - e0.start_edge + 1, e0.lat);
                    chk("res0", res0, e0.res);
                end
            end
        end
        pv1 = v1;
        pv0 = v0;
    end

    // Issues a start and pushes the expected sel trace, latency and snapshot.
    task automatic scan(input bit which, input logic [15:0] m, input logic [15:0] p, input bit sync);
        int   n;
        int   s;
        exp_t e;
        n = 0;
        s = which ? 1 : 0;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        if (which) begin
            start1 = 1'b1; mask1 = m; pat1 = p;
        end else begin
            start0 = 1'b1; mask0 = m; pat0 = p;
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (m[k]) begin
                n++;
                for (int r = 0; r <= s; r++) begin
                    if (which) sq1.push_back(4'(k));
                    else sq0.push_back(4'(k));
                end
            end
        end
        e.res        = p & m;
        e.lat        = 1 + n * (s + 1);
        e.start_edge = cyc;
        if (which) eq1.push_back(e);
        else eq0.push_back(e);
    endtask

    task automatic wait_valid(input bit which, input string name);
        int n;
        n = 0;
        while (!(which ? v1 : v0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, which ? v1 : v0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst    = 1'b1;
        start1 = 1'b0; start0 = 1'b0;
        mask1  = 16'd0; mask0 = 16'd0;
        pat1   = 16'd0; pat0  = 16'd0;
        rdy1   = 1'b1; rdy0  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_sel1", sel1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_valid1", v1, 0);
        chk("rst_result1", res1, 0);
        chk("rst_sel0", sel0, 0);
        chk("rst_valid0", v0, 0);

        // Full sweep, pattern per channel
        scan(1, 16'hFFFF, 16'hA5C3, 1);
        wait_valid(1, "t1_valid");
        @(posedge clk);

        // Only the end channels, mux tied high
        scan(1, 16'h8001, 16'hFFFF, 1);
        wait_valid(1, "t2_valid");
        @(posedge clk);

        // Empty mask goes straight to DONE
        scan(1, 16'h0000, 16'hFFFF, 1);
        wait_valid(1, "t3_valid");
        chk("t3_sel", sel1, 0);
        @(posedge clk);

        // Backpressure with a start pulse that must be ignored
        #1;
        rdy1 = 1'b0;
        scan(1, 16'h0F00, 16'h0A00, 1);
        wait_valid(1, "t4_valid");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            start1 = (i == 3);
            mask1  = (i == 3) ? 16'hFFFF : 16'h0F00;
            chk("t4_hold_result", res1, 16'h0A00);
            chk("t4_hold_sel", sel1, 11);
            chk("t4_hold_valid", v1, 1);
            chk("t4_not_busy", busy1, 0);
        end
        start1 = 1'b0;
        @(posedge clk);
        #1;
        rdy1 = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_idle_valid", v1, 0);
        chk("t4_idle_sel", sel1, 0);
        chk("t4_kept_result", res1, 16'h0A00);
        scan(1, 16'h0003, 16'h0002, 0);
        chk("t4_restart_busy", busy1, 1);
        wait_valid(1, "t4b_valid");
        @(posedge clk);

        // Reset mid-scan at sel=7
        scan(1, 16'hFFFF, 16'h12F4, 1);
        n = 0;
        while (sel1 != 4'd7 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_reach_sel7", sel1, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sq1.delete();
        eq1.delete();
        chk("t5_sel", sel1, 0);
        chk("t5_busy", busy1, 0);
        chk("t5_valid", v1, 0);
        chk("t5_result", res1, 0);
        scan(1, 16'h5A5A, 16'hFFFF, 1);
        wait_valid(1, "t5b_valid");
        @(posedge clk);

        // SETTLE=0 instance
        scan(0, 16'h00F0, 16'h0050, 1);
        wait_valid(0, "t6_valid");
        @(posedge clk);
        scan(0, 16'h8000, 16'h8000, 1);
        wait_valid(0, "t6b_valid");
        @(posedge clk);

        repeat (3) @(posedge clk);
        #1;
        chk("sq1_drained", sq1.size(), 0);
        chk("eq1_drained", eq1.size(), 0);
        chk("sq0_drained", sq0.size(), 0);
        chk("eq0_drained", eq0.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
